// File: rtl/arb_nmux_if.sv
// Handshake bundle between CH producers and the single arb_nmux output stage.
interface arb_nmux_if #(
  parameter int N  = 32,
  parameter int CH = 4
) ();
  localparam int SW = (CH > 1) ? $clog2(CH) : 1;

  logic [CH*N-1:0] in_data;
  logic [CH-1:0]   in_valid;
  logic [CH-1:0]   in_ready;
  logic [SW-1:0]   sel;
  logic [N-1:0]    out_data;
  logic            out_valid;
  logic            out_ready;
  logic [SW-1:0]   out_ch;

  modport master (
    output in_data, in_valid, sel, out_ready,
    input  in_ready, out_data, out_valid, out_ch
  );

  modport slave (
    input  in_data, in_valid, sel, out_ready,
    output in_ready, out_data, out_valid, out_ch
  );
endinterface

// File: rtl/arb_nmux.sv
// CH-to-1 valid/ready mux into a single-entry output register; select is external
// (MODE 0) or round-robin (MODE 1). Latency 1 clock, full throughput.
module arb_nmux #(
  parameter int N    = 32,
  parameter int CH   = 4,
  parameter int MODE = 0
) (
  input  logic          clk,
  input  logic          rst,
  arb_nmux_if.slave     bus
);
  localparam int SW = (CH > 1) ? $clog2(CH) : 1;

  logic [N-1:0]  out_data_q,  out_data_d;
  logic [SW-1:0] out_ch_q,    out_ch_d;
  logic          out_valid_q, out_valid_d;
  logic [SW-1:0] ptr_q,       ptr_d;

  logic [SW-1:0] gnt_idx;
  logic          gnt_vld;
  logic          load_en;
  logic          xfer;
  logic [N-1:0]  gnt_data;
  logic [CH-1:0] in_ready;

  // Grant search: iterate from the farthest offset down so the nearest valid
  // channel after ptr is the last (winning) assignment.
  always_comb begin
    int c;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    c       = 0;
    if (MODE == 0) begin
      gnt_idx = bus.sel;
      gnt_vld = (32'(bus.sel) < CH);
    end else begin
      for (int i = CH; i >= 1; i--) begin
        c = (int'(ptr_q) + i) % CH;
        if (bus.in_valid[c]) begin
          gnt_vld = 1'b1;
          gnt_idx = SW'(c);
        end
      end
    end
  end

  always_comb begin
    gnt_data = '0;
    for (int c = 0; c < CH; c++) begin
      if (gnt_idx == SW'(c)) begin
        gnt_data = bus.in_data[c*N +: N];
      end
    end
  end

  always_comb begin
    logic in_vld_g;
    in_vld_g = 1'b0;
    for (int c = 0; c < CH; c++) begin
      if (gnt_idx == SW'(c)) begin
        in_vld_g = bus.in_valid[c];
      end
    end
    load_en = !out_valid_q || bus.out_ready;
    xfer    = !rst && load_en && gnt_vld && in_vld_g;
  end

  always_comb begin
    in_ready = '0;
    for (int c = 0; c < CH; c++) begin
      if (xfer && gnt_idx == SW'(c)) begin
        in_ready[c] = 1'b1;
      end
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_data_d  = gnt_data;
      out_ch_d    = gnt_idx;
      out_valid_d = 1'b1;
      if (MODE == 1) begin
        ptr_d = gnt_idx;
      end
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // ptr resets to the last channel so channel 0 is searched first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= SW'(CH - 1);
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_valid = out_valid_q;

  a_rdy_onehot: assert property (@(posedge clk) disable iff (rst)
    $onehot0(in_ready));

  a_hold_stable: assert property (@(posedge clk) disable iff (rst)
    (out_valid_q && !bus.out_ready) |=> (out_valid_q && $stable(out_data_q) && $stable(out_ch_q)));
endmodule

// File: tb/tb_arb_nmux.sv
// Three instances (MODE0/CH4, MODE1/CH4, MODE0/CH3) driven side by side and
// checked against a per-instance reference model and output scoreboard.
module tb_arb_nmux;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  arb_nmux_if #(.N(32), .CH(4)) if0 ();
  arb_nmux_if #(.N(32), .CH(4)) if1 ();
  arb_nmux_if #(.N(32), .CH(3)) if2 ();

  arb_nmux #(.N(32), .CH(4), .MODE(0)) u0 (.clk(clk), .rst(rst), .bus(if0.slave));
  arb_nmux #(.N(32), .CH(4), .MODE(1)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));
  arb_nmux #(.N(32), .CH(3), .MODE(0)) u2 (.clk(clk), .rst(rst), .bus(if2.slave));

  logic [3:0]  iv   [3];
  logic [1:0]  sl   [3];
  logic        ordy [3];
  logic [31:0] dat  [3][4];

  assign if0.in_valid  = iv[0];
  assign if0.sel       = sl[0];
  assign if0.out_ready = ordy[0];
  assign if0.in_data   = {dat[0][3], dat[0][2], dat[0][1], dat[0][0]};
  assign if1.in_valid  = iv[1];
  assign if1.sel       = sl[1];
  assign if1.out_ready = ordy[1];
  assign if1.in_data   = {dat[1][3], dat[1][2], dat[1][1], dat[1][0]};
  assign if2.in_valid  = iv[2][2:0];
  assign if2.sel       = sl[2];
  assign if2.out_ready = ordy[2];
  assign if2.in_data   = {dat[2][2], dat[2][1], dat[2][0]};

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int grant(input int mode, input int nch, input int s,
                               input logic [3:0] v, input int ptr);
    if (mode == 0) return (s < nch) ? s : -1;
    for (int i = 1; i <= nch; i++) begin
      if (v[(ptr + i) % nch]) return (ptr + i) % nch;
    end
    return -1;
  endfunction

  // Reference model state and scoreboard of words expected at each output.
  logic        m_vld [3];
  int          m_ptr [3];
  logic [33:0] sb_q  [3][$];

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin : mdl
      logic [3:0]  rdy, exp_rdy;
      logic        ov, le, xf;
      logic [31:0] od;
      logic [1:0]  oc;
      logic [33:0] exp_w;
      int          nch, mode, g;
      nch  = (k == 2) ? 3 : 4;
      mode = (k == 1) ? 1 : 0;
      case (k)
        0:       begin rdy = if0.in_ready; ov = if0.out_valid; od = if0.out_data; oc = if0.out_ch; end
        1:       begin rdy = if1.in_ready; ov = if1.out_valid; od = if1.out_data; oc = if1.out_ch; end
        default: begin rdy = {1'b0, if2.in_ready}; ov = if2.out_valid; od = if2.out_data; oc = if2.out_ch; end
      endcase
      if (rst) begin
        m_vld[k] = 1'b0;
        m_ptr[k] = nch - 1;
        sb_q[k].delete();
        chk($sformatf("u%0d_rst_valid", k), 64'(ov), 64'd0);
        chk($sformatf("u%0d_rst_ready", k), 64'(rdy), 64'd0);
        chk($sformatf("u%0d_rst_data", k), 64'(od), 64'd0);
        chk($sformatf("u%0d_rst_ch", k), 64'(oc), 64'd0);
      end else begin
        le = !m_vld[k] || ordy[k];
        g  = grant(mode, nch, int'(sl[k]), iv[k], m_ptr[k]);
        xf = le && (g >= 0) && iv[k][g];
        exp_rdy = xf ? (4'b0001 << g) : 4'b0000;
        chk($sformatf("u%0d_in_ready", k), 64'(rdy), 64'(exp_rdy));
        chk($sformatf("u%0d_out_valid", k), 64'(ov), 64'(m_vld[k]));
        if (m_vld[k] && sb_q[k].size() > 0) begin
          exp_w = sb_q[k][0];
          chk($sformatf("u%0d_out_data", k), 64'(od), 64'(exp_w[31:0]));
          chk($sformatf("u%0d_out_ch", k), 64'(oc), 64'(exp_w[33:32]));
        end
        if (m_vld[k] && ordy[k]) begin
          void'(sb_q[k].pop_front());
          m_vld[k] = 1'b0;
        end
        if (xf) begin
          sb_q[k].push_back({2'(g), dat[k][g]});
          m_vld[k] = 1'b1;
          if (mode == 1) m_ptr[k] = g;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++)
        for (int c = 0; c < 4; c++) dat[k][c] = $urandom;
    end
  endtask

  initial begin
    logic [1:0] rr_exp [5];
    rr_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      iv[k] = '0; sl[k] = '0; ordy[k] = 1'b0;
      for (int c = 0; c < 4; c++) dat[k][c] = $urandom;
    end
    tick(2);
    rst = 1'b0;

    // External select of ch2, round-robin with all valid, CH=3 with sel out of range.
    sl[0] = 2'd2; iv[0] = 4'b0100; ordy[0] = 1'b1; dat[0][2] = 32'hDEADBEEF;
    iv[1] = 4'hF; ordy[1] = 1'b1;
    sl[2] = 2'd3; iv[2] = 4'h7; ordy[2] = 1'b1;
    tick(1);
    chk("sel2_data", 64'(if0.out_data), 64'hDEADBEEF);
    chk("sel2_ch", 64'(if0.out_ch), 64'd2);
    chk("sel2_valid", 64'(if0.out_valid), 64'd1);
    chk("sel3_ready", 64'(if2.in_ready), 64'd0);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("rr_seq%0d_ch", i), 64'(if1.out_ch), 64'(rr_exp[i]));
      chk($sformatf("rr_seq%0d_valid", i), 64'(if1.out_valid), 64'd1);
      if (i < 4) tick(1);
    end
    tick(3);
    chk("sel3_valid", 64'(if2.out_valid), 64'd0);

    // Sparse valids: only ch1/ch3 may win.
    iv[1] = 4'b1010;
    tick(8);

    // Downstream stall with a word held, then release.
    iv[1] = 4'hF; ordy[1] = 1'b1;
    tick(1);
    ordy[1] = 1'b0;
    tick(5);
    ordy[1] = 1'b1;
    tick(3);

    repeat (80) begin
      for (int k = 0; k < 3; k++) begin
        iv[k]   = 4'($urandom);
        sl[k]   = 2'($urandom_range(0, 3));
        ordy[k] = ($urandom_range(0, 3) != 0);
      end
      tick(1);
    end

    // Mid-stream asynchronous reset.
    iv[1] = 4'hF; ordy[1] = 1'b1;
    tick(3);
    chk("pre_rst_valid", 64'(if1.out_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk("arst_valid", 64'(if1.out_valid), 64'd0);
    chk("arst_data", 64'(if1.out_data), 64'd0);
    chk("arst_ch", 64'(if1.out_ch), 64'd0);
    tick(1);
    rst = 1'b0;
    tick(1);
    chk("post_rst_ch", 64'(if1.out_ch), 64'd0);
    chk("post_rst_valid", 64'(if1.out_valid), 64'd1);
    tick(4);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
